// File: rtl/fft_frame_loader.sv
// Serial-to-parallel frame loader feeding the 64-point FFT core: fill, zero-pad, start, wait.
// Optional FFT_LOADER_PRESCALE_EN: rounds and arithmetically shifts samples right by PRESCALE.
module fft_frame_loader #(
  parameter int D_WIDTH     = 64,
  parameter int LOG_2_WIDTH = 6,
  parameter int FFT_CYCLES  = 194,
  parameter int PRESCALE    = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [15:0]               s_re,
  input  logic [15:0]               s_im,
  input  logic                      s_last,
  input  logic                      ifft_req,
  output logic [D_WIDTH-1:0][15:0]  fft_re,
  output logic [D_WIDTH-1:0][15:0]  fft_im,
  output logic                      fft_start,
  output logic                      fft_ifft,
  output logic                      frame_done,
  output logic                      frame_err
);

  localparam int CNT_W = (FFT_CYCLES > 1) ? $clog2(FFT_CYCLES) : 1;
  localparam logic [LOG_2_WIDTH-1:0] LAST_IDX = LOG_2_WIDTH'(D_WIDTH - 1);
  localparam logic [CNT_W-1:0]       CNT_INIT = CNT_W'(FFT_CYCLES - 1);

  if (D_WIDTH != (1 << LOG_2_WIDTH) || PRESCALE < 1 || PRESCALE > 15) begin : g_param_check
    $error("fft_frame_loader: inconsistent D_WIDTH/LOG_2_WIDTH or PRESCALE out of range");
  end

  typedef enum logic [1:0] {FILL, PAD, LAUNCH, WAIT} state_t;

  state_t                     state_q, state_d;
  logic [LOG_2_WIDTH-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic                       ifft_q, ifft_d;
  logic [D_WIDTH-1:0][15:0]   re_q, re_d;
  logic [D_WIDTH-1:0][15:0]   im_q, im_d;

  function automatic logic [15:0] scale(input logic [15:0] x);
`ifdef FFT_LOADER_PRESCALE_EN
    logic signed [16:0] sum;
    logic signed [16:0] sh;
    // 17-bit sum keeps the rounding carry of 16'h7FFF; clamp guards the positive rail.
    sum = $signed({x[15], x}) + $signed(17'(1 << (PRESCALE - 1)));
    sh  = sum >>> PRESCALE;
    if (sh > 17'sh07FFF) return 16'h7FFF;
    return sh[15:0];
`else
    return x;
`endif
  endfunction

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    cnt_d      = cnt_q;
    ifft_d     = ifft_q;
    re_d       = re_q;
    im_d       = im_q;
    s_ready    = 1'b0;
    fft_start  = 1'b0;
    frame_done = 1'b0;
    frame_err  = 1'b0;
    case (state_q)
      FILL: begin
        s_ready = rst;
        if (s_valid && rst) begin
          re_d[wr_ptr_q] = scale(s_re);
          im_d[wr_ptr_q] = scale(s_im);
          if (wr_ptr_q == '0) ifft_d = ifft_req;
          if (wr_ptr_q == LAST_IDX) begin
            state_d   = LAUNCH;
            wr_ptr_d  = '0;
            frame_err = ~s_last;
          end else begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (s_last) state_d = PAD;
          end
        end
      end
      PAD: begin
        re_d[wr_ptr_q] = '0;
        im_d[wr_ptr_q] = '0;
        if (wr_ptr_q == LAST_IDX) begin
          state_d  = LAUNCH;
          wr_ptr_d = '0;
        end else begin
          wr_ptr_d = wr_ptr_q + 1'b1;
        end
      end
      LAUNCH: begin
        fft_start = 1'b1;
        cnt_d     = CNT_INIT;
        state_d   = WAIT;
      end
      WAIT: begin
        if (cnt_q == '0) begin
          frame_done = 1'b1;
          state_d    = FILL;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = FILL;
    endcase
  end

  // Falling-edge update to line up with the FFT core's sampling.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= FILL;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      ifft_q   <= 1'b0;
      re_q     <= '0;
      im_q     <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      ifft_q   <= ifft_d;
      re_q     <= re_d;
      im_q     <= im_d;
    end
  end

  assign fft_re   = re_q;
  assign fft_im   = im_q;
  assign fft_ifft = ifft_q;

endmodule

// File: tb/tb_fft_frame_loader.sv
// Directed bench for fft_frame_loader: table of frame scenarios plus reset and prescale sequences.
module tb_fft_frame_loader;

  logic                clk;
  logic                rst;
  logic                s_valid;
  logic                s_ready;
  logic [15:0]         s_re;
  logic [15:0]         s_im;
  logic                s_last;
  logic                ifft_req;
  logic [63:0][15:0]   fft_re;
  logic [63:0][15:0]   fft_im;
  logic                fft_start;
  logic                fft_ifft;
  logic                frame_done;
  logic                frame_err;

  fft_frame_loader #(
    .D_WIDTH    (64),
    .LOG_2_WIDTH(6),
    .FFT_CYCLES (194),
    .PRESCALE   (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_re      (s_re),
    .s_im      (s_im),
    .s_last    (s_last),
    .ifft_req  (ifft_req),
    .fft_re    (fft_re),
    .fft_im    (fft_im),
    .fft_start (fft_start),
    .fft_ifft  (fft_ifft),
    .frame_done(frame_done),
    .frame_err (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int n;      // samples sent
    bit last;   // mark final sample with s_last
    bit ifft;   // ifft_req on first sample (inverted afterwards)
    bit hold;   // keep s_valid high through LAUNCH/WAIT
    int lat;    // cycles from last accept to fft_start
    bit err;    // frame_err on final accept
  } frame_t;

  frame_t      tbl[5];
  logic [15:0] d_re[64];
  logic [15:0] d_im[64];
  int          n_vec;
  int          n_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] model(input logic [15:0] x);
`ifdef FFT_LOADER_PRESCALE_EN
    logic signed [16:0] s;
    s = $signed({x[15], x}) + 17'sd1;
    s = s >>> 1;
    if (s > 17'sd32767) return 16'h7FFF;
    return s[15:0];
`else
    return x;
`endif
  endfunction

  task automatic count_bad(input int n, output int bad);
    logic [15:0] er, ei;
    bad = 0;
    for (int j = 0; j < 64; j++) begin
      er = (j < n) ? model(d_re[j]) : 16'h0000;
      ei = (j < n) ? model(d_im[j]) : 16'h0000;
      if (fft_re[j] !== er || fft_im[j] !== ei) bad++;
    end
  endtask

  task automatic run_frame(input frame_t r);
    int c;
    int bad;
    int busy_ready;
    int extra_start;
    bit found;
    for (int i = 0; i < r.n; i++) begin
      s_valid  = 1'b1;
      s_re     = d_re[i];
      s_im     = d_im[i];
      s_last   = r.last && (i == r.n - 1);
      ifft_req = (i == 0) ? r.ifft : ~r.ifft;
      @(posedge clk);
      if (i == 0) chk("s_ready_fill", 32'(s_ready), 32'd1);
      if (i == r.n - 1) chk("frame_err_last", 32'(frame_err), 32'(r.err));
      else if (frame_err) chk("frame_err_mid", 32'(frame_err), 32'd0);
      @(negedge clk); #1;
    end
    s_valid = r.hold;
    s_re    = 16'h5555;
    s_im    = 16'h5555;
    s_last  = 1'b0;
    busy_ready = 0;
    c = 0;
    found = 1'b0;
    while (!found && c < 300) begin
      @(posedge clk);
      c++;
      if (fft_start) found = 1'b1;
      else begin
        if (s_ready) busy_ready++;
        @(negedge clk); #1;
      end
    end
    chk("start_latency", 32'(c), 32'(r.lat));
    count_bad(r.n, bad);
    chk("buf_at_start", 32'(bad), 32'd0);
    chk("fft_ifft", 32'(fft_ifft), 32'(r.ifft));
    @(negedge clk); #1;
    c = 0;
    found = 1'b0;
    extra_start = 0;
    while (!found && c < 400) begin
      @(posedge clk);
      c++;
      if (fft_start) extra_start++;
      if (s_ready) busy_ready++;
      if (frame_done) found = 1'b1;
      else begin
        @(negedge clk); #1;
      end
    end
    chk("done_latency", 32'(c), 32'd194);
    chk("start_one_cycle", 32'(extra_start), 32'd0);
    chk("no_ready_busy", 32'(busy_ready), 32'd0);
    count_bad(r.n, bad);
    chk("buf_at_done", 32'(bad), 32'd0);
    @(negedge clk); #1;
  endtask

  initial begin
    int bad;
    int starts;
    n_vec = 0;
    n_err = 0;
    tbl[0] = '{64, 1'b1, 1'b0, 1'b0, 1,  1'b0};  // full frame
    tbl[1] = '{10, 1'b1, 1'b1, 1'b1, 55, 1'b0};  // short frame, valid held through WAIT
    tbl[2] = '{64, 1'b0, 1'b1, 1'b0, 1,  1'b1};  // missing s_last
    tbl[3] = '{1,  1'b1, 1'b1, 1'b0, 64, 1'b0};  // s_last on first sample
    tbl[4] = '{63, 1'b1, 1'b0, 1'b0, 2,  1'b0};  // one pad entry

    rst = 1'b0; s_valid = 1'b1; s_re = 16'h1234; s_im = 16'h1234; s_last = 1'b0; ifft_req = 1'b1;
    #1;
    chk("rst_s_ready", 32'(s_ready), 32'd0);
    chk("rst_fft_start", 32'(fft_start), 32'd0);
    chk("rst_fft_ifft", 32'(fft_ifft), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    count_bad(0, bad);
    chk("rst_buf", 32'(bad), 32'd0);
    @(negedge clk); @(negedge clk); #1;
    count_bad(0, bad);
    chk("rst_buf_held", 32'(bad), 32'd0);
    rst = 1'b1; s_valid = 1'b0;

    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < 64; i++) begin
        d_re[i] = 16'(i + 256 * k);
        d_im[i] = 16'(-(i + 256 * k));
      end
      run_frame(tbl[k]);
    end
    s_valid = 1'b0;

    // Reset while padding at wr_ptr 30: 6 samples, then 24 pad cycles.
    for (int i = 0; i < 6; i++) begin
      s_valid  = 1'b1;
      s_re     = 16'(100 + i);
      s_im     = 16'(200 + i);
      s_last   = (i == 5);
      ifft_req = 1'b1;
      @(negedge clk); #1;
    end
    s_valid = 1'b0; s_last = 1'b0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk); #1;
    end
    rst = 1'b0;
    #1;
    count_bad(0, bad);
    chk("midpad_rst_buf", 32'(bad), 32'd0);
    chk("midpad_rst_ready", 32'(s_ready), 32'd0);
    chk("midpad_rst_ifft", 32'(fft_ifft), 32'd0);
    @(negedge clk); #1;
    rst = 1'b1;
    @(posedge clk);
    chk("midpad_release_ready", 32'(s_ready), 32'd1);
    starts = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      if (fft_start) starts++;
    end
    chk("midpad_no_start", 32'(starts), 32'd0);
    count_bad(0, bad);
    chk("midpad_buf_after", 32'(bad), 32'd0);
    @(negedge clk); #1;

    // Prescale corner values on a single-sample frame.
    d_re[0] = 16'h7FFF;
    d_im[0] = 16'hFFFD;
    run_frame('{1, 1'b1, 1'b0, 1'b0, 64, 1'b0});
`ifdef FFT_LOADER_PRESCALE_EN
    chk("prescale_re_max", 32'(fft_re[0]), 32'h4000);
    chk("prescale_im_neg3", 32'(fft_im[0]), 32'hFFFF);
`else
    chk("raw_re_max", 32'(fft_re[0]), 32'h7FFF);
    chk("raw_im_neg3", 32'(fft_im[0]), 32'hFFFD);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
